// File: rtl/exfifo_pkt_bridge.sv
// ---------------------------------------------------------------------------
// exfifo_pkt_bridge
//
// Packet-buffering bridge between the host control stream and the NIOS CPU's
// external-FIFO PIO ports. Each direction has a circular buffer. Words only
// become visible to the reader once the complete fixed-length packet they
// belong to has been written.
//
// Ports:
//   clk                 single clock for all logic
//   reset               synchronous active-high reset
//   host_in_data/valid  inbound word from host; host_in_ready = room in FIFO
//   exfifo_if_d         show-ahead head word of the inbound FIFO
//   exfifo_if_rdempty   no committed inbound word available
//   exfifo_if_rd        CPU pops the inbound head word
//   exfifo_of_d/wr      outbound word and write strobe from the CPU
//   exfifo_of_wrfull    outbound FIFO full
//   exfifo_rst          CPU-driven synchronous flush of both directions
//   host_out_data/valid committed outbound head word for the host
//   host_out_ready      host accepts the outbound head word
//   in_ovf              sticky: CPU read while inbound side was empty
//   out_ovf             sticky: CPU write while outbound side was full
// ---------------------------------------------------------------------------

// One direction: circular buffer with a partial-packet counter and a count of
// committed (readable) words. Pushes beyond the buffer capacity are dropped
// and pops of uncommitted words are ignored; the caller flags both.
module exfifo_pkt_fifo #(
  parameter int DATA_W    = 32,
  parameter int PKT_WORDS = 16,
  parameter int DEPTH     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_req,
  input  logic              pop_req,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              avail
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] PKT_CNT  = CW'(PKT_WORDS);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [PW-1:0] LAST_IDX = PW'(PKT_WORDS - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     fill;
  logic [CW-1:0]     committed;
  logic [PW-1:0]     partial;

  logic push_ok;
  logic pop_ok;
  logic commit;

  assign full    = (fill == FULL_CNT);
  assign avail   = (committed != '0);
  assign push_ok = push_req && !full;
  assign pop_ok  = pop_req && avail;
  // The word completing a packet releases the whole packet at once.
  assign commit  = push_ok && (partial == LAST_IDX);

  // Gated so the data output reads 0 while nothing committed is present,
  // which also gives a defined value straight out of reset.
  assign head_data = avail ? mem[rd_ptr] : '0;

  // Storage array is not reset; only the bookkeeping below decides validity.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, fill, partial and committed counts. DEPTH is a power of two so
  // the pointers wrap naturally by overflowing.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      committed <= '0;
      partial   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr  <= wr_ptr + AW'(1);
        partial <= commit ? '0 : partial + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   fill <= fill + ONE_CNT;
        2'b01:   fill <= fill - ONE_CNT;
        default: fill <= fill;
      endcase
      committed <= committed + (commit ? PKT_CNT : '0) - (pop_ok ? ONE_CNT : '0);
    end
  end

endmodule

module exfifo_pkt_bridge #(
  parameter int DATA_W    = 32,
  parameter int PKT_WORDS = 16,
  parameter int DEPTH     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] host_in_data,
  input  logic              host_in_valid,
  output logic              host_in_ready,
  output logic [DATA_W-1:0] exfifo_if_d,
  output logic              exfifo_if_rdempty,
  input  logic              exfifo_if_rd,
  input  logic [DATA_W-1:0] exfifo_of_d,
  input  logic              exfifo_of_wr,
  output logic              exfifo_of_wrfull,
  input  logic              exfifo_rst,
  output logic [DATA_W-1:0] host_out_data,
  output logic              host_out_valid,
  input  logic              host_out_ready,
  output logic              in_ovf,
  output logic              out_ovf
);

  // Hardware reset and the CPU flush have identical effect on both paths.
  logic flush;
  logic in_full;
  logic in_avail;
  logic out_full;
  logic out_avail;

  assign flush = reset || exfifo_rst;

  exfifo_pkt_fifo #(
    .DATA_W    (DATA_W),
    .PKT_WORDS (PKT_WORDS),
    .DEPTH     (DEPTH)
  ) u_in (
    .clk       (clk),
    .reset     (flush),
    .push_data (host_in_data),
    .push_req  (host_in_valid),
    .pop_req   (exfifo_if_rd),
    .head_data (exfifo_if_d),
    .full      (in_full),
    .avail     (in_avail)
  );

  exfifo_pkt_fifo #(
    .DATA_W    (DATA_W),
    .PKT_WORDS (PKT_WORDS),
    .DEPTH     (DEPTH)
  ) u_out (
    .clk       (clk),
    .reset     (flush),
    .push_data (exfifo_of_d),
    .push_req  (exfifo_of_wr),
    .pop_req   (host_out_ready),
    .head_data (host_out_data),
    .full      (out_full),
    .avail     (out_avail)
  );

  assign host_in_ready     = !in_full;
  assign exfifo_if_rdempty = !in_avail;
  assign exfifo_of_wrfull  = out_full;
  assign host_out_valid    = out_avail;

  // Sticky error flags for CPU misuse; only a reset or flush clears them,
  // and a same-cycle flush wins over a new error.
  always_ff @(posedge clk) begin
    if (flush) begin
      in_ovf  <= 1'b0;
      out_ovf <= 1'b0;
    end else begin
      if (exfifo_if_rd && !in_avail) begin
        in_ovf <= 1'b1;
      end
      if (exfifo_of_wr && out_full) begin
        out_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_exfifo_pkt_bridge.sv
// ---------------------------------------------------------------------------
// tb_exfifo_pkt_bridge
//
// Self-checking bench for exfifo_pkt_bridge. A queue-based reference model
// tracks the words held in each direction plus how many trailing words belong
// to a not-yet-complete packet; everything the DUT shows is predicted from it.
// Directed phases walk through the packet, flush, full, wrap and overflow
// scenarios, followed by a long randomized run.
// ---------------------------------------------------------------------------
module tb_exfifo_pkt_bridge;

  localparam int DATA_W = 32;
  localparam int PKT    = 16;
  localparam int DEPTH  = 32;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] host_in_data;
  logic              host_in_valid;
  logic              host_in_ready;
  logic [DATA_W-1:0] exfifo_if_d;
  logic              exfifo_if_rdempty;
  logic              exfifo_if_rd;
  logic [DATA_W-1:0] exfifo_of_d;
  logic              exfifo_of_wr;
  logic              exfifo_of_wrfull;
  logic              exfifo_rst;
  logic [DATA_W-1:0] host_out_data;
  logic              host_out_valid;
  logic              host_out_ready;
  logic              in_ovf;
  logic              out_ovf;

  int vectors;
  int miscompares;

  // Reference model state: stored words and length of the incomplete tail.
  logic [DATA_W-1:0] in_q[$];
  logic [DATA_W-1:0] out_q[$];
  int                in_pend;
  int                out_pend;
  logic              m_in_ovf;
  logic              m_out_ovf;

  exfifo_pkt_bridge #(
    .DATA_W    (DATA_W),
    .PKT_WORDS (PKT),
    .DEPTH     (DEPTH)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .host_in_data      (host_in_data),
    .host_in_valid     (host_in_valid),
    .host_in_ready     (host_in_ready),
    .exfifo_if_d       (exfifo_if_d),
    .exfifo_if_rdempty (exfifo_if_rdempty),
    .exfifo_if_rd      (exfifo_if_rd),
    .exfifo_of_d       (exfifo_of_d),
    .exfifo_of_wr      (exfifo_of_wr),
    .exfifo_of_wrfull  (exfifo_of_wrfull),
    .exfifo_rst        (exfifo_rst),
    .host_out_data     (host_out_data),
    .host_out_valid    (host_out_valid),
    .host_out_ready    (host_out_ready),
    .in_ovf            (in_ovf),
    .out_ovf           (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] got,
                             input logic [DATA_W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare all visible DUT state against the model.
  task automatic checkAll();
    int in_commit;
    int out_commit;
    in_commit  = in_q.size() - in_pend;
    out_commit = out_q.size() - out_pend;
    checkOutput("host_in_ready", 32'(host_in_ready), 32'(in_q.size() < DEPTH));
    checkOutput("if_rdempty", 32'(exfifo_if_rdempty), 32'(in_commit == 0));
    if (in_commit > 0) checkOutput("if_d", exfifo_if_d, in_q[0]);
    checkOutput("of_wrfull", 32'(exfifo_of_wrfull), 32'(out_q.size() == DEPTH));
    checkOutput("host_out_valid", 32'(host_out_valid), 32'(out_commit != 0));
    if (out_commit > 0) checkOutput("host_out_data", host_out_data, out_q[0]);
    checkOutput("in_ovf", 32'(in_ovf), 32'(m_in_ovf));
    checkOutput("out_ovf", 32'(out_ovf), 32'(m_out_ovf));
    checkOutput("in_commit_le_fill",
                32'(dut.u_in.committed <= dut.u_in.fill), 32'd1);
    checkOutput("out_commit_le_fill",
                32'(dut.u_out.committed <= dut.u_out.fill), 32'd1);
  endtask

  // Advance the model by one clock given the inputs applied this cycle.
  task automatic modelStep(input logic hv, input logic [DATA_W-1:0] hd,
                           input logic rd, input logic ow,
                           input logic [DATA_W-1:0] od, input logic ordy,
                           input logic flush);
    int  in_commit;
    int  out_commit;
    logic in_push;
    logic in_pop;
    logic out_push;
    logic out_pop;
    if (flush) begin
      in_q.delete();
      out_q.delete();
      in_pend   = 0;
      out_pend  = 0;
      m_in_ovf  = 1'b0;
      m_out_ovf = 1'b0;
      return;
    end
    in_commit  = in_q.size() - in_pend;
    out_commit = out_q.size() - out_pend;
    in_push  = hv && (in_q.size() < DEPTH);
    in_pop   = rd && (in_commit > 0);
    out_push = ow && (out_q.size() < DEPTH);
    out_pop  = ordy && (out_commit > 0);
    if (rd && in_commit == 0) m_in_ovf = 1'b1;
    if (ow && out_q.size() == DEPTH) m_out_ovf = 1'b1;
    if (in_pop) void'(in_q.pop_front());
    if (in_push) begin
      in_q.push_back(hd);
      in_pend = (in_pend + 1) % PKT;
    end
    if (out_pop) void'(out_q.pop_front());
    if (out_push) begin
      out_q.push_back(od);
      out_pend = (out_pend + 1) % PKT;
    end
  endtask

  // Drive one cycle of inputs, step the model, then check after the edge.
  task automatic applyStimulus(input logic hv, input logic [DATA_W-1:0] hd,
                               input logic rd, input logic ow,
                               input logic [DATA_W-1:0] od, input logic ordy,
                               input logic xrst, input logic rst);
    host_in_valid  = hv;
    host_in_data   = hd;
    exfifo_if_rd   = rd;
    exfifo_of_wr   = ow;
    exfifo_of_d    = od;
    host_out_ready = ordy;
    exfifo_rst     = xrst;
    reset          = rst;
    modelStep(hv, hd, rd, ow, od, ordy, xrst || rst);
    @(posedge clk);
    @(negedge clk);
    checkAll();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    in_pend     = 0;
    out_pend    = 0;
    m_in_ovf    = 1'b0;
    m_out_ovf   = 1'b0;
    reset          = 1'b1;
    host_in_valid  = 1'b0;
    host_in_data   = '0;
    exfifo_if_rd   = 1'b0;
    exfifo_of_wr   = 1'b0;
    exfifo_of_d    = '0;
    host_out_ready = 1'b0;
    exfifo_rst     = 1'b0;

    // Reset state, including the zeroed data outputs.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("rst_if_d", exfifo_if_d, '0);
    checkOutput("rst_host_out_data", host_out_data, '0);
    idle(1);

    // One full packet in, then read back; one extra read flags in_ovf.
    for (int i = 0; i < PKT; i++) applyStimulus(1, 32'h100 + i, 0, 0, 0, 0, 0, 0);
    checkOutput("pkt1_visible", 32'(exfifo_if_rdempty), 32'd0);
    for (int i = 0; i < PKT; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("pkt1_drained", 32'(exfifo_if_rdempty), 32'd1);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("in_ovf_set", 32'(in_ovf), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("in_ovf_cleared", 32'(in_ovf), 32'd0);

    // Partial packet discarded by the CPU flush.
    for (int i = 0; i < PKT - 1; i++) applyStimulus(1, 32'h1F0 + i, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < PKT; i++) applyStimulus(1, 32'h200 + i, 0, 0, 0, 0, 0, 0);
    checkOutput("after_flush_head", exfifo_if_d, 32'h200);
    for (int i = 0; i < PKT; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);

    // Fill the inbound side completely, overrun, then free one slot.
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1, 32'h300 + i, 0, 0, 0, 0, 0, 0);
    checkOutput("in_full_ready", 32'(host_in_ready), 32'd0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("in_ready_back", 32'(host_in_ready), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);

    // Three packets with interleaved reads so the pointers wrap.
    for (int i = 0; i < 3 * PKT; i++)
      applyStimulus(1, 32'h400 + i, (i % 3) != 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2 * DEPTH; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);

    // Outbound: packet held until complete, fill to full, overflow, drain.
    for (int i = 0; i < PKT; i++) applyStimulus(0, 0, 0, 1, 32'h500 + i, 0, 0, 0);
    checkOutput("out_valid_pkt", 32'(host_out_valid), 32'd1);
    for (int i = PKT; i < DEPTH + 1; i++) applyStimulus(0, 0, 0, 1, 32'h500 + i, 0, 0, 0);
    checkOutput("out_ovf_set", 32'(out_ovf), 32'd1);
    checkOutput("out_head_intact", host_out_data, 32'h500);
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);

    // Randomized traffic in both directions with rare flushes.
    for (int i = 0; i < 4000; i++) begin
      applyStimulus(($urandom % 10) < 7, $urandom, ($urandom % 10) < 4,
                    ($urandom % 10) < 6, $urandom, ($urandom % 10) < 4,
                    ($urandom % 400) == 0, ($urandom % 1500) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
